weight_buffer_sequencer: RTL and testbench
==========================================

WEIGHT_BUFFER_SEQUENCER -- requirements
Module: weight_buffer_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 6: width of the weight-buffer row index (64 rows).
REQ-002 The block SHALL have parameter READ_LATENCY, default 2: cycles from index driven to weight data valid (address register plus RAM read).
REQ-003 The block SHALL have parameter PASS_WIDTH, default 8: width of the pass (timestep) counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: single-cycle request to begin a sequence.
REQ-007 The block SHALL have port last_row, input, ADDR_WIDTH bits: index of the final row per pass, sampled on an accepted start.
REQ-008 The block SHALL have port num_passes, input, PASS_WIDTH bits: passes over rows 0..last_row, sampled on an accepted start; a value of 0 is treated as 1.
REQ-009 The block SHALL have port pause, input, 1 bit: while high, no new index is issued.
REQ-010 The block SHALL have port index, output, ADDR_WIDTH bits: row index driven to the weight buffer.
REQ-011 The block SHALL have port w_valid, output, 1 bit: weight-buffer outputs hold data for an issued index this cycle.
REQ-012 The block SHALL have port w_last_row, output, 1 bit: qualifies w_valid data as belonging to last_row.
REQ-013 The block SHALL have port pass_count, output, PASS_WIDTH bits: zero-based number of the current issuing pass.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, DRAIN and DONE.
REQ-017 In IDLE, start SHALL latch last_row and num_passes, clear the row and pass counters, and move to ISSUE; start is ignored in every other state.
REQ-018 In ISSUE with pause=0, each cycle SHALL issue one index equal to the row counter, then increment that counter.
REQ-019 When the row counter equals last_row in ISSUE, the counter SHALL wrap to 0 and pass_count SHALL increment.
REQ-020 The issue of the last row of the final pass SHALL move the FSM to DRAIN.
REQ-021 In ISSUE with pause=1, index SHALL hold its value, the counters SHALL hold, and a 0 SHALL enter the valid pipeline (a bubble).
REQ-022 w_valid SHALL equal the issue flag delayed exactly READ_LATENCY cycles, and w_last_row SHALL be delayed identically, so data for an index issued in cycle T is flagged in cycle T+READ_LATENCY.
REQ-023 DRAIN SHALL last exactly READ_LATENCY cycles, then move to DONE.
REQ-024 DONE SHALL assert done for exactly one cycle, one cycle after the final w_valid, then return to IDLE.
REQ-025 pause SHALL have no effect in DRAIN, DONE or IDLE.
REQ-026 In IDLE, index SHALL be 0.
REQ-027 last_row=0 SHALL produce one index per pass.
REQ-028 When last_row = 2^ADDR_WIDTH-1, the row counter SHALL wrap naturally with no overflow flag.
REQ-029 pass_count SHALL hold its final value until the next accepted start.

Reset
REQ-030 On reset the FSM SHALL enter IDLE, with index, pass_count, w_valid, w_last_row, busy and done all 0 after the clock edge.
REQ-031 On reset the valid pipeline SHALL be cleared, so no w_valid occurs for indices issued before reset.
REQ-032 Reset SHALL take priority over start in the same cycle.
REQ-033 Reset mid-sequence SHALL abort the sequence without asserting done.

Structure
REQ-034 Shared package weight_seq_pkg SHALL hold the state enum and the default ADDR_WIDTH, READ_LATENCY and PASS_WIDTH constants.
REQ-035 Sub-module valid_delay_line SHALL implement a parameterised READ_LATENCY-deep, 2-bit (valid, last_row) shift register with synchronous reset.
REQ-036 No storage beyond the counters, the FSM and the delay line is permitted.

Verification
REQ-037 Scenario: last_row=63, num_passes=1, pause=0 -> index 0..63 on consecutive cycles; w_valid high 64 cycles starting 2 cycles after the first issue; w_last_row on the 64th; done one cycle later.
REQ-038 Scenario: last_row=3, num_passes=3 -> index 0,1,2,3 repeated three times; pass_count steps 0,1,2; exactly 12 w_valid; one done.
REQ-039 Scenario: pause high for 2 cycles after index=5 is issued -> index holds 5 during the pause; w_valid shows a 2-cycle gap; total w_valid count unchanged.
REQ-040 Scenario: start re-pulsed during ISSUE, and start in the DONE cycle -> both ignored; exactly one done per accepted start.
REQ-041 Scenario: reset asserted at the 10th issue -> the next cycle shows IDLE with all outputs 0; no w_valid or done follows.
REQ-042 Scenario: num_passes=0 with last_row=0 -> a single index 0, one w_valid with w_last_row=1, then done.

Source files
------------

// File: rtl/weight_buffer_sequencer_pkg.sv
// Shared types and default sizing for the weight-buffer row sequencer.
package weight_seq_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH   = 6;
  localparam int unsigned DEFAULT_READ_LATENCY = 2;
  localparam int unsigned DEFAULT_PASS_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/weight_buffer_sequencer_if.sv
// Control and weight-buffer signals of the sequencer; slave is the sequencer side.
interface weight_buffer_sequencer_if
  import weight_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned PASS_WIDTH = DEFAULT_PASS_WIDTH
);

  logic                  start;
  logic [ADDR_WIDTH-1:0] last_row;
  logic [PASS_WIDTH-1:0] num_passes;
  logic                  pause;
  logic [ADDR_WIDTH-1:0] index;
  logic                  w_valid;
  logic                  w_last_row;
  logic [PASS_WIDTH-1:0] pass_count;
  logic                  busy;
  logic                  done;

  modport master (
    output start, last_row, num_passes, pause,
    input  index, w_valid, w_last_row, pass_count, busy, done
  );

  modport slave (
    input  start, last_row, num_passes, pause,
    output index, w_valid, w_last_row, pass_count, busy, done
  );

endinterface

// File: rtl/weight_buffer_sequencer_delay.sv
// DEPTH-stage shift register carrying the (valid, last_row) issue flags.
module valid_delay_line
  import weight_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_READ_LATENCY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] in_i,
  output logic [1:0] out_o
);

  logic [1:0] pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= in_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign out_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/weight_buffer_sequencer.sv
// Issues weight-buffer row indices 0..last_row for num_passes passes and flags
// returning data READ_LATENCY cycles later.
module weight_buffer_sequencer
  import weight_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int unsigned READ_LATENCY = DEFAULT_READ_LATENCY,
  parameter int unsigned PASS_WIDTH   = DEFAULT_PASS_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  weight_buffer_sequencer_if.slave  bus
);

  localparam int unsigned DW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [ADDR_WIDTH-1:0] last_row_q, last_row_d;
  logic [PASS_WIDTH-1:0] pass_q, pass_d;
  logic [PASS_WIDTH-1:0] pass_end_q, pass_end_d;
  logic [DW-1:0]         drain_q, drain_d;

  logic issue;
  logic at_last_row;
  logic final_issue;
  logic [1:0] dly_out;

  assign issue       = (state_q == ISSUE) && !bus.pause;
  assign at_last_row = (row_q == last_row_q);
  assign final_issue = issue && at_last_row && (pass_q == pass_end_q);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    index_d    = index_q;
    last_row_d = last_row_q;
    pass_d     = pass_q;
    pass_end_d = pass_end_q;
    drain_d    = drain_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          last_row_d = bus.last_row;
          // Store the final pass number so zero passes collapses to one.
          pass_end_d = (bus.num_passes == '0) ? '0 : bus.num_passes - PASS_WIDTH'(1);
          row_d      = '0;
          pass_d     = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          index_d = row_q;
          if (at_last_row) begin
            row_d = '0;
            if (final_issue) begin
              drain_d = '0;
              state_d = DRAIN;
            end else begin
              pass_d = pass_q + PASS_WIDTH'(1);
            end
          end else begin
            row_d = row_q + ADDR_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == DW'(READ_LATENCY - 1)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      DONE: begin
        index_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      index_q    <= '0;
      last_row_q <= '0;
      pass_q     <= '0;
      pass_end_q <= '0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      index_q    <= index_d;
      last_row_q <= last_row_d;
      pass_q     <= pass_d;
      pass_end_q <= pass_end_d;
      drain_q    <= drain_d;
    end
  end

  valid_delay_line #(
    .DEPTH(READ_LATENCY)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .in_i  ({issue, issue && at_last_row}),
    .out_o (dly_out)
  );

  assign bus.index      = index_q;
  assign bus.w_valid    = dly_out[1];
  assign bus.w_last_row = dly_out[0];
  assign bus.pass_count = pass_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);

endmodule

// File: tb/tb_weight_buffer_sequencer.sv
// Directed bench: per-cycle vector table plus modelled multi-cycle sequences.
module tb_weight_buffer_sequencer;

  localparam int unsigned AW = 6;
  localparam int unsigned PW = 8;
  localparam int unsigned RL = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  weight_buffer_sequencer_if #(.ADDR_WIDTH(AW), .PASS_WIDTH(PW)) bus ();

  weight_buffer_sequencer #(
    .ADDR_WIDTH  (AW),
    .READ_LATENCY(RL),
    .PASS_WIDTH  (PW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit rst;
    bit start;
    int lr;
    int np;
    bit pause;
    int idx;
    bit wv;
    bit wl;
    int pc;
    bit busy;
    bit done;
  } vec_t;

  vec_t vecs [25];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Modelled sequence: tracks row/pass/last-issued index and a 2-deep
  // {valid, last_row, final} pipe; optionally pauses, aborts or re-pulses start.
  task automatic run_seq(input int lr, input int np, input int pause_row, input int pause_len,
                         input int abort_at, input bit noise);
    int passes, total, row, pass, idx, issued, pause_left, vcnt, lcnt, dcnt;
    bit [2:0] p0, p1;
    bit issue_now, abort_now, fin, fin_seen, done_exp, prev_done, ended;
    passes = (np == 0) ? 1 : np;
    total  = (lr + 1) * passes;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.last_row   = AW'(lr);
    bus.num_passes = PW'(np);
    bus.pause      = 1'b0;
    @(posedge clk); #1;
    chk("seq_start_busy", int'(bus.busy), 1);
    chk("seq_start_index", int'(bus.index), 0);
    row = 0; pass = 0; idx = 0; issued = 0; pause_left = 0;
    vcnt = 0; lcnt = 0; dcnt = 0; p0 = '0; p1 = '0;
    fin_seen = 0; prev_done = 0; ended = 0;
    for (int cyc = 0; cyc < 1000 && !ended; cyc++) begin
      @(negedge clk);
      abort_now = (abort_at >= 0) && (issued == abort_at);
      bus.start = noise && (cyc == 3 || prev_done);
      bus.pause = (pause_left > 0);
      reset     = abort_now;
      issue_now = !abort_now && (issued < total) && (pause_left == 0);
      @(posedge clk); #1;
      if (abort_now) begin
        chk("abort_index", int'(bus.index), 0);
        chk("abort_pass", int'(bus.pass_count), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_wvalid", int'(bus.w_valid), 0);
        chk("abort_wlast", int'(bus.w_last_row), 0);
        chk("abort_done", int'(bus.done), 0);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          reset     = 1'b0;
          bus.start = 1'b0;
          bus.pause = 1'b0;
          @(posedge clk); #1;
          chk("post_abort_wvalid", int'(bus.w_valid), 0);
          chk("post_abort_done", int'(bus.done), 0);
          chk("post_abort_busy", int'(bus.busy), 0);
        end
        ended = 1;
      end else begin
        fin = issue_now && (row == lr) && (pass == passes - 1);
        p1 = p0;
        p0 = {issue_now, issue_now && (row == lr), fin};
        done_exp = fin_seen;
        fin_seen = p1[0];
        if (pause_left > 0) pause_left--;
        else if (issue_now && row == pause_row) pause_left = pause_len;
        if (issue_now) begin
          idx = row;
          issued++;
          if (row == lr) begin
            row = 0;
            if (pass < passes - 1) pass++;
          end else begin
            row++;
          end
        end
        if (prev_done) idx = 0;
        chk("seq_index", int'(bus.index), idx);
        chk("seq_pass", int'(bus.pass_count), pass);
        chk("seq_wvalid", int'(bus.w_valid), int'(p1[2]));
        chk("seq_wlast", int'(bus.w_last_row), int'(p1[1]));
        chk("seq_done", int'(bus.done), int'(done_exp));
        chk("seq_busy", int'(bus.busy), int'(!prev_done));
        vcnt += int'(bus.w_valid);
        lcnt += int'(bus.w_last_row);
        dcnt += int'(bus.done);
        if (prev_done) ended = 1;
        prev_done = done_exp;
      end
    end
    bus.start = 1'b0;
    bus.pause = 1'b0;
    if (!ended) chk("seq_timeout", 0, 1);
    else if (abort_at < 0) begin
      chk("seq_valid_count", vcnt, total);
      chk("seq_last_count", lcnt, passes);
      chk("seq_done_count", dcnt, 1);
    end
  endtask

  initial begin
    //             rst st lr np pa  idx wv wl pc by dn
    vecs[0]  = '{1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 2, 2, 0,   0, 0, 0, 0, 1, 0};
    vecs[2]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0};
    vecs[3]  = '{0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0};
    vecs[4]  = '{0, 0, 0, 0, 1,   1, 1, 0, 0, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 0,   2, 0, 0, 1, 1, 0};
    vecs[6]  = '{0, 0, 0, 0, 0,   0, 1, 1, 1, 1, 0};
    vecs[7]  = '{0, 0, 0, 0, 0,   1, 1, 0, 1, 1, 0};
    vecs[8]  = '{0, 0, 0, 0, 0,   2, 1, 0, 1, 1, 0};
    vecs[9]  = '{0, 1, 5, 5, 1,   2, 1, 1, 1, 1, 0};
    vecs[10] = '{0, 0, 0, 0, 0,   2, 0, 0, 1, 1, 1};
    vecs[11] = '{0, 1, 1, 1, 0,   0, 0, 0, 1, 0, 0};
    vecs[12] = '{0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0};
    vecs[13] = '{0, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0};
    vecs[14] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0};
    vecs[15] = '{0, 0, 0, 0, 0,   0, 1, 1, 0, 1, 0};
    vecs[16] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1};
    vecs[17] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    vecs[18] = '{0, 1, 3, 1, 0,   0, 0, 0, 0, 1, 0};
    vecs[19] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0};
    vecs[20] = '{0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0};
    vecs[21] = '{1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    vecs[22] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    vecs[23] = '{1, 1, 2, 1, 0,   0, 0, 0, 0, 0, 0};
    vecs[24] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.last_row   = '0;
    bus.num_passes = '0;
    bus.pause      = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      reset          = vecs[i].rst;
      bus.start      = vecs[i].start;
      bus.last_row   = AW'(vecs[i].lr);
      bus.num_passes = PW'(vecs[i].np);
      bus.pause      = vecs[i].pause;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_index", i), int'(bus.index), vecs[i].idx);
      chk($sformatf("vec%0d_wvalid", i), int'(bus.w_valid), int'(vecs[i].wv));
      chk($sformatf("vec%0d_wlast", i), int'(bus.w_last_row), int'(vecs[i].wl));
      chk($sformatf("vec%0d_pass", i), int'(bus.pass_count), vecs[i].pc);
      chk($sformatf("vec%0d_busy", i), int'(bus.busy), int'(vecs[i].busy));
      chk($sformatf("vec%0d_done", i), int'(bus.done), int'(vecs[i].done));
    end
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;

    run_seq(63, 1, -1, 0, -1, 1'b0);
    run_seq(3, 3, -1, 0, -1, 1'b1);
    run_seq(7, 1, 5, 2, -1, 1'b0);
    run_seq(4, 3, -1, 0, 9, 1'b0);
    run_seq(0, 0, -1, 0, -1, 1'b0);
    run_seq(63, 2, 63, 1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
